// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared mode codes, FSM state encoding and schedule helpers for the ghost
// behaviour scheduler.
package ghost_mode_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_FRIGHT  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCHED  = 2'd1,
    ST_FRIGHT = 2'd2,
    ST_FINAL  = 2'd3
  } state_e;

  localparam int unsigned PHASE_W = 5;

  // Even phases scatter, odd phases chase.
  function automatic int unsigned phase_len(input logic [PHASE_W-1:0] idx,
                                            input int unsigned scatter_s,
                                            input int unsigned chase_s);
    return idx[0] ? chase_s : scatter_s;
  endfunction

endpackage

// File: rtl/ghost_mode_scheduler_sec_down_timer.sv
// Loadable seconds down-counter; load wins over enable, decrement stops at zero.
module sec_down_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost-behaviour scheduler: scatter/chase schedule, permanent chase,
// per-ghost frightened override with flash warning and reverse pulse.
module ghost_mode_scheduler
  import ghost_mode_scheduler_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS = 4,
  parameter int unsigned NUM_PAIRS  = 4,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned SCATTER_S  = 7,
  parameter int unsigned CHASE_S    = 20,
  parameter int unsigned FRIGHT_S   = 6,
  parameter int unsigned FLASH_S    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  one_hz_enable,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  power_pellet,
  input  logic [NUM_GHOSTS-1:0] ghost_eaten,
  output logic [1:0]            mode,
  output logic                  chase,
  output logic [NUM_GHOSTS-1:0] frightened,
  output logic                  flash,
  output logic                  reverse,
  output logic [PHASE_W-1:0]    phase_idx,
  output logic [CNT_W-1:0]      secs_left
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(2 * NUM_PAIRS);

  state_e                state_q, state_d;
  state_e                saved_q, saved_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [NUM_GHOSTS-1:0] fright_q, fright_d;
  logic                  reverse_q, reverse_d;

  logic                  s_load, s_en, s_zero;
  logic [CNT_W-1:0]      s_load_val, s_count;
  logic                  f_load, f_en, f_zero;
  logic [CNT_W-1:0]      f_load_val, f_count;

  logic                  tick;
  logic [PHASE_W-1:0]    phase_next;
  mode_e                 mode_c;

  assign tick       = one_hz_enable && !pause;
  assign phase_next = phase_q + PHASE_W'(1);

  sec_down_timer #(.CNT_W(CNT_W)) u_sched_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (s_load),
    .load_val (s_load_val),
    .en       (s_en),
    .count    (s_count),
    .zero     (s_zero)
  );

  sec_down_timer #(.CNT_W(CNT_W)) u_fright_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (f_load),
    .load_val (f_load_val),
    .en       (f_en),
    .count    (f_count),
    .zero     (f_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      saved_q   <= ST_SCHED;
      phase_q   <= '0;
      fright_q  <= '0;
      reverse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      phase_q   <= phase_d;
      fright_q  <= fright_d;
      reverse_q <= reverse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    phase_d    = phase_q;
    fright_d   = fright_q;
    reverse_d  = 1'b0;
    s_load     = 1'b0;
    s_load_val = '0;
    s_en       = 1'b0;
    f_load     = 1'b0;
    f_load_val = '0;
    f_en       = 1'b0;

    if (start) begin
      state_d    = ST_SCHED;
      phase_d    = '0;
      s_load     = 1'b1;
      s_load_val = CNT_W'(SCATTER_S);
      f_load     = 1'b1;
      fright_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_SCHED, ST_FINAL: begin
          if (power_pellet) begin
            // Schedule timer is left untouched so SCHED resumes where it stopped.
            state_d    = ST_FRIGHT;
            saved_d    = state_q;
            f_load     = 1'b1;
            f_load_val = CNT_W'(FRIGHT_S);
            fright_d   = '1;
            reverse_d  = 1'b1;
          end else if ((state_q == ST_SCHED) && tick && !s_zero) begin
            if (s_count == CNT_W'(1)) begin
              phase_d   = phase_next;
              reverse_d = 1'b1;
              s_load    = 1'b1;
              if (phase_next == LAST_PHASE) begin
                state_d = ST_FINAL;
              end else begin
                s_load_val = CNT_W'(phase_len(phase_next, SCATTER_S, CHASE_S));
              end
            end else begin
              s_en = 1'b1;
            end
          end
        end
        ST_FRIGHT: begin
          if (power_pellet) begin
            f_load     = 1'b1;
            f_load_val = CNT_W'(FRIGHT_S);
            fright_d   = '1;
            reverse_d  = 1'b1;
          end else begin
            fright_d = fright_q & ~ghost_eaten;
            if (tick && !f_zero) begin
              f_en = 1'b1;
              if (f_count == CNT_W'(1)) begin
                fright_d = '0;
                state_d  = saved_q;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so there is no input-to-output path.
  always_comb begin
    mode_c = MODE_SCATTER;
    unique case (state_q)
      ST_IDLE:   mode_c = MODE_SCATTER;
      ST_SCHED:  mode_c = phase_q[0] ? MODE_CHASE : MODE_SCATTER;
      ST_FRIGHT: mode_c = MODE_FRIGHT;
      ST_FINAL:  mode_c = MODE_CHASE;
      default:   mode_c = MODE_SCATTER;
    endcase
  end

  always_comb begin
    secs_left = '0;
    if (state_q == ST_SCHED) begin
      secs_left = s_count;
    end else if (state_q == ST_FRIGHT) begin
      secs_left = f_count;
    end
  end

  assign mode       = mode_c;
  assign chase      = (mode_c == MODE_CHASE);
  assign frightened = fright_q;
  assign flash      = (state_q == ST_FRIGHT) && !f_zero && (f_count <= CNT_W'(FLASH_S));
  assign reverse    = reverse_q;
  assign phase_idx  = phase_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_ghost_mode_scheduler;

  localparam int NP = 2;
  localparam int SC = 3;
  localparam int CH = 5;
  localparam int FR = 4;
  localparam int FL = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_hz_enable, start, pause, power_pellet;
  logic [3:0] ghost_eaten;
  logic [1:0] mode;
  logic       chase, flash, reverse;
  logic [3:0] frightened;
  logic [4:0] phase_idx;
  logic [5:0] secs_left;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  ghost_mode_scheduler #(
    .NUM_GHOSTS (4),
    .NUM_PAIRS  (NP),
    .CNT_W      (6),
    .SCATTER_S  (SC),
    .CHASE_S    (CH),
    .FRIGHT_S   (FR),
    .FLASH_S    (FL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .one_hz_enable (one_hz_enable),
    .start         (start),
    .pause         (pause),
    .power_pellet  (power_pellet),
    .ghost_eaten   (ghost_eaten),
    .mode          (mode),
    .chase         (chase),
    .frightened    (frightened),
    .flash         (flash),
    .reverse       (reverse),
    .phase_idx     (phase_idx),
    .secs_left     (secs_left)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a running/final/frightened flag set plus integer timers.
  bit       m_run, m_final, m_fon, m_rev, m_tk;
  int       m_phase, m_sleft, m_fleft;
  bit [3:0] m_fr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_final = 0; m_fon = 0; m_rev = 0;
      m_phase = 0; m_sleft = 0; m_fleft = 0; m_fr = '0;
    end else begin
      m_tk  = one_hz_enable && !pause;
      m_rev = 0;
      if (start) begin
        m_run = 1; m_final = 0; m_fon = 0; m_phase = 0;
        m_sleft = SC; m_fleft = 0; m_fr = '0;
      end else if (m_run) begin
        if (power_pellet) begin
          m_fon = 1; m_fleft = FR; m_fr = '1; m_rev = 1;
        end else if (m_fon) begin
          m_fr = m_fr & ~ghost_eaten;
          if (m_tk) begin
            m_fleft = m_fleft - 1;
            if (m_fleft == 0) begin
              m_fon = 0; m_fr = '0;
            end
          end
        end else if (!m_final && m_tk) begin
          m_sleft = m_sleft - 1;
          if (m_sleft == 0) begin
            m_phase = m_phase + 1;
            m_rev   = 1;
            if (m_phase == 2 * NP) m_final = 1;
            else m_sleft = (m_phase % 2 == 1) ? CH : SC;
          end
        end
      end
    end
  end

  function automatic int exp_mode();
    if (!m_run) return 0;
    if (m_fon) return 2;
    return (m_final || (m_phase % 2 == 1)) ? 1 : 0;
  endfunction

  function automatic int exp_secs();
    if (m_fon) return m_fleft;
    if (m_run && !m_final) return m_sleft;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.mode",       32'(mode),       32'(exp_mode()));
      chk("m.chase",      32'(chase),      32'(exp_mode() == 1));
      chk("m.frightened", 32'(frightened), 32'(m_fr));
      chk("m.flash",      32'(flash),      32'(m_fon && m_fleft >= 1 && m_fleft <= FL));
      chk("m.reverse",    32'(reverse),    32'(m_rev));
      chk("m.phase_idx",  32'(phase_idx),  32'(m_phase));
      chk("m.secs_left",  32'(secs_left),  32'(exp_secs()));
    end
  end

  task automatic step(input bit tk, input bit pel, input bit st, input logic [3:0] ge);
    one_hz_enable = tk; power_pellet = pel; start = st; ghost_eaten = ge;
    @(posedge clk);
    #1;
    one_hz_enable = 0; power_pellet = 0; start = 0; ghost_eaten = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".mode"},  32'(mode), 0);
    chk({tag, ".fr"},    32'(frightened), 0);
    chk({tag, ".flash"}, 32'(flash), 0);
    chk({tag, ".rev"},   32'(reverse), 0);
    chk({tag, ".phase"}, 32'(phase_idx), 0);
    chk({tag, ".secs"},  32'(secs_left), 0);
  endtask

  int rev_cnt;

  initial begin
    reset = 0; one_hz_enable = 0; start = 0; pause = 0; power_pellet = 0; ghost_eaten = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("t1.rst");
    reset = 1;
    cmp_en = 1;

    // T1: no start, ticks and pellets ignored
    for (int i = 0; i < 10; i++) begin
      step(1, (i == 4), 0, '0);
      chk("t1.mode", 32'(mode), 0);
      chk("t1.phase", 32'(phase_idx), 0);
    end

    // T2: full schedule
    step(0, 0, 1, '0);
    chk("t2.mode0", 32'(mode), 0);
    chk("t2.secs0", 32'(secs_left), 3);
    rev_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, '0);
      if (reverse) rev_cnt++;
      if (i == 3) begin
        chk("t2.ph1", 32'(phase_idx), 1);
        chk("t2.ph1secs", 32'(secs_left), 5);
      end
      if (i == 11) chk("t2.ph3", 32'(phase_idx), 3);
    end
    chk("t2.revcnt", 32'(rev_cnt), 4);
    chk("t2.final_chase", 32'(chase), 1);
    chk("t2.final_phase", 32'(phase_idx), 4);
    chk("t2.final_secs", 32'(secs_left), 0);
    step(1, 0, 0, '0);
    chk("t2.final_hold", 32'(mode), 1);

    // T3: pellet in phase 1 with 2 s left
    step(0, 0, 1, '0);
    repeat (6) step(1, 0, 0, '0);
    chk("t3.pre_secs", 32'(secs_left), 2);
    chk("t3.pre_phase", 32'(phase_idx), 1);
    step(0, 1, 0, '0);
    chk("t3.mode", 32'(mode), 2);
    chk("t3.fr", 32'(frightened), 4'b1111);
    chk("t3.rev", 32'(reverse), 1);
    chk("t3.fsecs", 32'(secs_left), 4);
    chk("t3.flash4", 32'(flash), 0);
    step(1, 0, 0, '0); chk("t3.flash3", 32'(flash), 0);
    step(1, 0, 0, '0); chk("t3.flash2", 32'(flash), 1);
    step(1, 0, 0, '0); chk("t3.flash1", 32'(flash), 1);
    step(1, 0, 0, '0);
    chk("t3.back_mode", 32'(mode), 1);
    chk("t3.back_secs", 32'(secs_left), 2);
    chk("t3.back_rev", 32'(reverse), 0);
    chk("t3.back_flash", 32'(flash), 0);

    // T4: eaten ghosts, pellet re-extends fright
    step(0, 1, 0, '0);
    step(0, 0, 0, 4'b0101);
    chk("t4.eaten", 32'(frightened), 4'b1010);
    repeat (3) step(1, 0, 0, '0);
    chk("t4.fsecs1", 32'(secs_left), 1);
    step(0, 1, 0, '0);
    chk("t4.reload", 32'(secs_left), 4);
    chk("t4.allset", 32'(frightened), 4'b1111);
    chk("t4.flash", 32'(flash), 0);
    repeat (4) step(1, 0, 0, '0);
    chk("t4.exit_mode", 32'(mode), 1);

    // T5: same-cycle priorities
    step(0, 0, 1, '0);
    repeat (2) step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    chk("t5.pel_tick_mode", 32'(mode), 2);
    chk("t5.pel_tick_phase", 32'(phase_idx), 0);
    step(0, 1, 0, 4'b0110);
    chk("t5.pel_eaten", 32'(frightened), 4'b1111);
    step(0, 1, 1, '0);
    chk("t5.start_mode", 32'(mode), 0);
    chk("t5.start_fr", 32'(frightened), 0);
    chk("t5.start_secs", 32'(secs_left), 3);

    // T6: pause, then async reset in FRIGHT
    pause = 1;
    repeat (5) step(1, 0, 0, '0);
    chk("t6.pause_secs", 32'(secs_left), 3);
    pause = 0;
    step(0, 1, 0, '0);
    #2;
    reset = 0;
    #1;
    chk_reset_vals("t6.async");
    step(0, 0, 0, '0);
    reset = 1;

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) pause = ~pause;
      if ($urandom_range(999) == 0) begin
        reset = 0;
        step(0, 0, 0, '0);
        reset = 1;
      end
      step(($urandom_range(2) == 0), ($urandom_range(39) == 0), ($urandom_range(199) == 0),
           ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'b0000);
    end

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
